// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS subset control FSM with memory handshake, wait timeout and sticky fault
module multicycle_control #(
    parameter int ALUCTRL_W = 4,
    parameter int TIMEOUT   = 16,
    parameter int EN_ADDI   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           Opcode,
    input  logic [5:0]           Func,
    input  logic                 Zero,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 IorD,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 MemtoReg,
    output logic                 RegDst,
    output logic                 RegWrite,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           PCSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 fault,
    output logic [3:0]           state
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(4'b0010);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(4'b0110);
    localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(4'b0000);
    localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(4'b0001);
    localparam logic [ALUCTRL_W-1:0] ALU_SLT = ALUCTRL_W'(4'b0111);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_BEQ      = 4'd8,
        S_ADDI_EX  = 4'd9,
        S_ADDI_WB  = 4'd10,
        S_JUMP     = 4'd11,
        S_FAULT    = 4'd12
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             fault_q, fault_d;
    logic             func_legal;
    logic             waiting;
    logic             timeout_hit;

    always_comb begin
        func_legal  = Func inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        waiting     = (state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR) && !mem_ready;
        // this wait cycle would be the TIMEOUT-th one; mem_ready in the same cycle still advances
        timeout_hit = wait_cnt_q >= CNT_W'(TIMEOUT - 1);

        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : (timeout_hit ? S_FAULT : S_FETCH);
            S_DECODE: begin
                case (Opcode)
                    6'b000000:            state_d = func_legal ? S_RTYPE_EX : S_FAULT;
                    6'b100011, 6'b101011: state_d = S_MEMADR;
                    6'b000100:            state_d = S_BEQ;
                    6'b000010:            state_d = S_JUMP;
                    6'b001000:            state_d = (EN_ADDI != 0) ? S_ADDI_EX : S_FAULT;
                    default:              state_d = S_FAULT;
                endcase
            end
            S_MEMADR: begin
                case (Opcode)
                    6'b100011: state_d = S_MEMRD;
                    6'b101011: state_d = S_MEMWR;
                    default:   state_d = S_FAULT;
                endcase
            end
            S_MEMRD:    state_d = mem_ready ? S_MEMWB : (timeout_hit ? S_FAULT : S_MEMRD);
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWR:    state_d = mem_ready ? S_FETCH : (timeout_hit ? S_FAULT : S_MEMWR);
            S_RTYPE_EX: state_d = S_RTYPE_WB;
            S_RTYPE_WB: state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_ADDI_EX:  state_d = S_ADDI_WB;
            S_ADDI_WB:  state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_FAULT:    state_d = S_FAULT;
            default:    state_d = S_FAULT;
        endcase

        wait_cnt_d = (waiting && state_d == state_q) ? wait_cnt_q + CNT_W'(1) : '0;
        fault_d    = fault_q | (state_d == S_FAULT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            fault_q    <= fault_d;
        end
    end

    // Moore decode of state; FETCH IRWrite/PCWrite and BEQ PCWrite also depend on inputs
    always_comb begin
        PCWrite    = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        MemtoReg   = 1'b0;
        RegDst     = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        ALUControl = '0;
        fault      = fault_q;
        state      = state_q;
        case (state_q)
            S_FETCH: begin
                MemRead    = 1'b1;
                ALUSrcB    = 2'b01;
                ALUControl = ALU_ADD;
                IRWrite    = mem_ready;
                PCWrite    = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                ALUControl = ALU_ADD;
            end
            S_MEMADR, S_ADDI_EX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = ALU_ADD;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_RTYPE_EX: begin
                ALUSrcA = 1'b1;
                case (Func)
                    6'b100010: ALUControl = ALU_SUB;
                    6'b100100: ALUControl = ALU_AND;
                    6'b100101: ALUControl = ALU_OR;
                    6'b101010: ALUControl = ALU_SLT;
                    default:   ALUControl = ALU_ADD;
                endcase
            end
            S_RTYPE_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSrc      = 2'b01;
                PCWrite    = Zero;
            end
            S_ADDI_WB: RegWrite = 1'b1;
            S_JUMP: begin
                PCSrc   = 2'b10;
                PCWrite = 1'b1;
            end
            default: ;
        endcase
        // the reset cycle must never issue a write or read strobe
        if (reset) begin
            PCWrite    = 1'b0;
            IorD       = 1'b0;
            MemRead    = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            MemtoReg   = 1'b0;
            RegDst     = 1'b0;
            RegWrite   = 1'b0;
            ALUSrcA    = 1'b0;
            ALUSrcB    = 2'b00;
            PCSrc      = 2'b00;
            ALUControl = '0;
            fault      = 1'b0;
            state      = 4'd0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control (dut0 EN_ADDI=1, dut1 EN_ADDI=0)
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, func;
    logic       zero, mem_ready;

    logic [1:0] pcw, iord, mrd, mwr, irw, m2r, rdst, rgw, srca, flt;
    logic [1:0] srcb  [2];
    logic [1:0] pcsrc [2];
    logic [3:0] aluc  [2];
    logic [3:0] st    [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        multicycle_control #(.ALUCTRL_W(4), .TIMEOUT(16), .EN_ADDI(g == 0 ? 1 : 0)) u_dut (
            .clk        (clk),
            .reset      (reset),
            .Opcode     (opcode),
            .Func       (func),
            .Zero       (zero),
            .mem_ready  (mem_ready),
            .PCWrite    (pcw[g]),
            .IorD       (iord[g]),
            .MemRead    (mrd[g]),
            .MemWrite   (mwr[g]),
            .IRWrite    (irw[g]),
            .MemtoReg   (m2r[g]),
            .RegDst     (rdst[g]),
            .RegWrite   (rgw[g]),
            .ALUSrcA    (srca[g]),
            .ALUSrcB    (srcb[g]),
            .PCSrc      (pcsrc[g]),
            .ALUControl (aluc[g]),
            .fault      (flt[g]),
            .state      (st[g])
        );
    end

    typedef struct {
        int          dut;
        string       name;
        logic [3:0]  st;
        logic [4:0]  strb;
        logic        flt;
        logic [11:0] aux;
        logic [11:0] mask;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [3:0] FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5,
                           RTEX = 6, RTWB = 7, BEQ = 8, ADDIEX = 9, ADDIWB = 10, JUMP = 11, FAULT = 12;
    // strobe order {PCWrite, IRWrite, MemRead, MemWrite, RegWrite}
    localparam logic [4:0] SB_0 = 5'b00000, SB_FETCH = 5'b11100, SB_MRD = 5'b00100,
                           SB_MWR = 5'b00010, SB_RW = 5'b00001, SB_PCW = 5'b10000;
    // aux order {IorD, MemtoReg, RegDst, ALUSrcA, ALUSrcB[1:0], PCSrc[1:0], ALUControl[3:0]}
    localparam logic [11:0] M_ALL = 12'hFFF, M_FETCH = 12'h9FF, M_EX = 12'h1CF, M_WB = 12'h600,
                            M_IORD = 12'h800, M_BEQ = 12'h1FF, M_PCSRC = 12'h030, M_RDST = 12'h200,
                            M_NONE = 12'h000;
    localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0110;

    function automatic logic [11:0] ax(input logic io, input logic mr, input logic rd, input logic sa,
                                       input logic [1:0] sb, input logic [1:0] ps, input logic [3:0] al);
        return {io, mr, rd, sa, sb, ps, al};
    endfunction

    task automatic drive(input logic r, input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input logic rdy);
        @(posedge clk);
        #1;
        reset = r; opcode = op; func = fn; zero = z; mem_ready = rdy;
    endtask

    task automatic expect_out(input int d, input string nm, input logic [3:0] s, input logic [4:0] sb,
                              input logic f, input logic [11:0] a, input logic [11:0] m);
        exp_t e;
        e.dut = d; e.name = nm; e.st = s; e.strb = sb; e.flt = f; e.aux = a; e.mask = m;
        q.push_back(e);
    endtask

    exp_t        e_mon;
    logic [4:0]  a_strb;
    logic [11:0] a_aux;

    always @(negedge clk) begin
        while (q.size() > 0) begin
            e_mon  = q.pop_front();
            a_strb = {pcw[e_mon.dut], irw[e_mon.dut], mrd[e_mon.dut], mwr[e_mon.dut], rgw[e_mon.dut]};
            a_aux  = {iord[e_mon.dut], m2r[e_mon.dut], rdst[e_mon.dut], srca[e_mon.dut],
                      srcb[e_mon.dut], pcsrc[e_mon.dut], aluc[e_mon.dut]};
            checks++;
            if (st[e_mon.dut] !== e_mon.st) begin
                errors++;
                $display("FAIL %s state dut%0d got %0d want %0d", e_mon.name, e_mon.dut, st[e_mon.dut], e_mon.st);
            end
            checks++;
            if (a_strb !== e_mon.strb) begin
                errors++;
                $display("FAIL %s strobes dut%0d got %b want %b", e_mon.name, e_mon.dut, a_strb, e_mon.strb);
            end
            checks++;
            if (flt[e_mon.dut] !== e_mon.flt) begin
                errors++;
                $display("FAIL %s fault dut%0d got %b want %b", e_mon.name, e_mon.dut, flt[e_mon.dut], e_mon.flt);
            end
            if (e_mon.mask != 12'h000) begin
                checks++;
                if ((a_aux & e_mon.mask) !== (e_mon.aux & e_mon.mask)) begin
                    errors++;
                    $display("FAIL %s muxsel dut%0d got %h want %h", e_mon.name, e_mon.dut,
                             a_aux & e_mon.mask, e_mon.aux & e_mon.mask);
                end
            end
        end
    end

    task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn, input string nm);
        drive(0, op, fn, 0, 1);
        expect_out(0, {nm, "_fetch"}, FETCH, SB_FETCH, 0, ax(0, 0, 0, 0, 2'b01, 2'b00, ADD), M_FETCH);
        drive(0, op, fn, 0, 1);
        expect_out(0, {nm, "_decode"}, DECODE, SB_0, 0, ax(0, 0, 0, 0, 2'b11, 2'b00, ADD), M_EX);
    endtask

    task automatic run_rtype(input logic [5:0] fn, input logic [3:0] alu, input string nm);
        fetch_decode(6'h00, fn, nm);
        drive(0, 6'h00, fn, 0, 1);
        expect_out(0, {nm, "_ex"}, RTEX, SB_0, 0, ax(0, 0, 0, 1, 2'b00, 2'b00, alu), M_EX);
        drive(0, 6'h00, fn, 0, 1);
        expect_out(0, {nm, "_wb"}, RTWB, SB_RW, 0, ax(0, 0, 1, 0, 2'b00, 2'b00, 4'h0), M_WB);
    endtask

    task automatic do_reset(input string nm);
        drive(1, 6'h00, 6'h00, 0, 1);
        expect_out(0, nm, 4'd0, SB_0, 0, 12'h000, M_ALL);
    endtask

    initial begin
        reset = 1'b1; opcode = 6'h00; func = 6'h00; zero = 1'b0; mem_ready = 1'b0;

        do_reset("reset0");
        do_reset("reset1");

        run_rtype(6'h20, 4'b0010, "add");
        run_rtype(6'h22, 4'b0110, "sub");
        run_rtype(6'h24, 4'b0000, "and");
        run_rtype(6'h25, 4'b0001, "or");
        run_rtype(6'h2A, 4'b0111, "slt");

        // lw with three wait cycles in MEMRD
        fetch_decode(6'h23, 6'h00, "lw");
        drive(0, 6'h23, 0, 0, 1);
        expect_out(0, "lw_adr", MEMADR, SB_0, 0, ax(0, 0, 0, 1, 2'b10, 2'b00, ADD), M_EX);
        for (int i = 0; i < 3; i++) begin
            drive(0, 6'h23, 0, 0, 0);
            expect_out(0, "lw_rd_wait", MEMRD, SB_MRD, 0, ax(1, 0, 0, 0, 0, 0, 0), M_IORD);
        end
        drive(0, 6'h23, 0, 0, 1);
        expect_out(0, "lw_rd", MEMRD, SB_MRD, 0, ax(1, 0, 0, 0, 0, 0, 0), M_IORD);
        drive(0, 6'h23, 0, 0, 1);
        expect_out(0, "lw_wb", MEMWB, SB_RW, 0, ax(0, 1, 0, 0, 0, 0, 0), M_WB);

        fetch_decode(6'h2B, 6'h00, "sw");
        drive(0, 6'h2B, 0, 0, 1);
        expect_out(0, "sw_adr", MEMADR, SB_0, 0, ax(0, 0, 0, 1, 2'b10, 2'b00, ADD), M_EX);
        drive(0, 6'h2B, 0, 0, 1);
        expect_out(0, "sw_wr", MEMWR, SB_MWR, 0, ax(1, 0, 0, 0, 0, 0, 0), M_IORD);

        fetch_decode(6'h04, 6'h00, "beq1");
        drive(0, 6'h04, 0, 1, 1);
        expect_out(0, "beq_taken", BEQ, SB_PCW, 0, ax(0, 0, 0, 1, 2'b00, 2'b01, SUB), M_BEQ);
        fetch_decode(6'h04, 6'h00, "beq0");
        drive(0, 6'h04, 0, 0, 1);
        expect_out(0, "beq_not", BEQ, SB_0, 0, ax(0, 0, 0, 1, 2'b00, 2'b01, SUB), M_BEQ);

        fetch_decode(6'h02, 6'h00, "j");
        drive(0, 6'h02, 0, 0, 1);
        expect_out(0, "j_jump", JUMP, SB_PCW, 0, ax(0, 0, 0, 0, 0, 2'b10, 0), M_PCSRC);

        // addi: dut0 decodes it, dut1 treats it as illegal
        drive(0, 6'h08, 0, 0, 1);
        expect_out(0, "addi_fetch", FETCH, SB_FETCH, 0, 12'h000, M_NONE);
        expect_out(1, "addi_fetch", FETCH, SB_FETCH, 0, 12'h000, M_NONE);
        drive(0, 6'h08, 0, 0, 1);
        expect_out(0, "addi_decode", DECODE, SB_0, 0, 12'h000, M_NONE);
        expect_out(1, "addi_decode", DECODE, SB_0, 0, 12'h000, M_NONE);
        drive(0, 6'h08, 0, 0, 1);
        expect_out(0, "addi_ex", ADDIEX, SB_0, 0, ax(0, 0, 0, 1, 2'b10, 2'b00, ADD), M_EX);
        expect_out(1, "addi_illegal", FAULT, SB_0, 1, 12'h000, M_NONE);
        drive(0, 6'h08, 0, 0, 1);
        expect_out(0, "addi_wb", ADDIWB, SB_RW, 0, 12'h000, M_RDST);
        expect_out(1, "addi_illegal_hold", FAULT, SB_0, 1, 12'h000, M_NONE);
        drive(1, 6'h00, 0, 0, 1);
        expect_out(0, "rst_a", 4'd0, SB_0, 0, 12'h000, M_ALL);
        expect_out(1, "rst_a", 4'd0, SB_0, 0, 12'h000, M_ALL);

        // illegal opcode: fault held 20 cycles, cleared by reset
        fetch_decode(6'h3F, 6'h00, "badop");
        for (int i = 0; i < 20; i++) begin
            drive(0, 6'h3F, 0, 1, 1);
            expect_out(0, "badop_fault", FAULT, SB_0, 1, 12'h000, M_NONE);
        end
        do_reset("rst_b");

        fetch_decode(6'h00, 6'h27, "badfn");
        for (int i = 0; i < 2; i++) begin
            drive(0, 6'h00, 6'h27, 0, 1);
            expect_out(0, "badfn_fault", FAULT, SB_0, 1, 12'h000, M_NONE);
        end
        do_reset("rst_c");

        // FETCH timeout: 16 waiting cycles then FAULT
        for (int i = 0; i < 16; i++) begin
            drive(0, 6'h02, 0, 0, 0);
            expect_out(0, "to_wait", FETCH, SB_MRD, 0, 12'h000, M_NONE);
        end
        drive(0, 6'h02, 0, 0, 0);
        expect_out(0, "to_fault", FAULT, SB_0, 1, 12'h000, M_NONE);
        do_reset("rst_d");

        // ready on the 16th cycle wins over timeout
        for (int i = 0; i < 15; i++) begin
            drive(0, 6'h02, 0, 0, 0);
            expect_out(0, "edge_wait", FETCH, SB_MRD, 0, 12'h000, M_NONE);
        end
        drive(0, 6'h02, 0, 0, 1);
        expect_out(0, "edge_ready", FETCH, SB_FETCH, 0, 12'h000, M_NONE);
        drive(0, 6'h02, 0, 0, 1);
        expect_out(0, "edge_decode", DECODE, SB_0, 0, 12'h000, M_NONE);
        drive(0, 6'h02, 0, 0, 1);
        expect_out(0, "edge_jump", JUMP, SB_PCW, 0, 12'h000, M_NONE);

        // reset in MEMWR abandons the store
        fetch_decode(6'h2B, 6'h00, "swr");
        drive(0, 6'h2B, 0, 0, 1);
        expect_out(0, "swr_adr", MEMADR, SB_0, 0, 12'h000, M_NONE);
        drive(1, 6'h2B, 0, 0, 1);
        expect_out(0, "swr_rst", 4'd0, SB_0, 0, 12'h000, M_ALL);
        drive(0, 6'h02, 0, 0, 1);
        expect_out(0, "swr_after", FETCH, SB_FETCH, 0, 12'h000, M_NONE);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
